// File: rtl/wisc_pkg.sv
// wisc_pkg
//   Types and constants shared by the WISC decode and writeback stages.
//   DATA_W / ADDR_W / NUM_REGS : register file geometry.
//   ZERO_REG                   : address of the hardwired-zero register.
//   reg_addr_t / reg_data_t    : register address and register data types.
package wisc_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = 4'd0;
endpackage

// File: rtl/reg_file_2r1w_write_decoder.sv
// WriteDecoder_4_16
//   One-hot write wordline generator for the register file.
//   RegId    in  4  destination register address.
//   WriteReg in  1  write enable.
//   Wordline out 16 one-hot select, all zero when WriteReg is low.
module WriteDecoder_4_16 (
    input  logic [3:0]  RegId,
    input  logic        WriteReg,
    output logic [15:0] Wordline
);
    // The ternary (rather than an AND with a replicated enable) keeps an X on
    // WriteReg confined to the addressed bit: bits that are 0 in both arms
    // resolve to 0 even when the select is unknown.
    assign Wordline = WriteReg ? (16'h0001 << RegId) : 16'h0000;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w
//   16 x 16 register file with two combinational read ports, one clocked
//   write port, optional same-cycle write-to-read bypass and R0 tied to zero.
//   clk       in  1   system clock, writes on the rising edge.
//   rst_n     in  1   asynchronous active-low reset, clears every entry.
//   SrcReg1/2 in  4   read addresses.
//   DstReg    in  4   write address.
//   WriteReg  in  1   write enable.
//   DstData   in  16  write data.
//   SrcData1/2 out 16 read data.
module reg_file_2r1w
    import wisc_pkg::*;
#(
    parameter int DATA_W    = wisc_pkg::DATA_W,
    parameter int ADDR_W    = wisc_pkg::ADDR_W,
    parameter int NUM_REGS  = wisc_pkg::NUM_REGS,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);
    logic [15:0]             wordline;
    logic [DATA_W-1:0]       regs_reg [NUM_REGS];
    logic [1:0][ADDR_W-1:0]  src_addr;
    logic                    write_live;

    WriteDecoder_4_16 u_write_decoder (
        .RegId    (DstReg),
        .WriteReg (WriteReg),
        .Wordline (wordline)
    );

    // Entry 0 is cleared by reset and never loaded afterwards, so it stays
    // zero; the read path masks it as well so the bypass cannot leak into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wordline[i]) begin
                    regs_reg[i] <= DstData;
                end
            end
        end
    end

    assign src_addr   = {SrcReg2, SrcReg1};
    assign write_live = WriteReg && (DstReg != ZERO_REG);

    // One identical read port per instance of this loop; priority is
    // R0 mask, then bypass, then the stored value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic [DATA_W-1:0] rd_data;

            always_comb begin
                rd_data = regs_reg[src_addr[gi]];
                if ((BYPASS_EN != 0) && write_live && (src_addr[gi] == DstReg)) begin
                    rd_data = DstData;
                end
                if (src_addr[gi] == ZERO_REG) begin
                    rd_data = '0;
                end
            end
        end
    endgenerate

    assign SrcData1 = g_read[0].rd_data;
    assign SrcData2 = g_read[1].rd_data;
endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;
    logic        clk;
    logic        rst_n;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] byp_a, byp_b;   // BYPASS_EN = 1 instance
    logic [15:0] nob_a, nob_b;   // BYPASS_EN = 0 instance

    int n_checks;
    int n_fail;

    // Architectural view of the register file: what each register holds.
    logic [15:0] ref_regs [16];

    reg_file_2r1w #(.BYPASS_EN(1)) dut_byp (
        .clk(clk), .rst_n(rst_n),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .SrcData1(byp_a), .SrcData2(byp_b)
    );

    reg_file_2r1w #(.BYPASS_EN(0)) dut_nob (
        .clk(clk), .rst_n(rst_n),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .SrcData1(nob_a), .SrcData2(nob_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a read of addr should produce this cycle according to the rules:
    // R0 is zero, a live write to the same address is forwarded if enabled,
    // otherwise the architectural contents.
    function automatic logic [15:0] expect_read(input logic [3:0] addr, input bit bypass);
        if (addr == 4'd0) return 16'h0000;
        if (bypass && WriteReg === 1'b1 && DstReg != 4'd0 && addr == DstReg) return DstData;
        return ref_regs[addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0000;
    endtask

    task automatic drive(input logic we, input logic [3:0] dst, input logic [15:0] data,
                         input logic [3:0] s1, input logic [3:0] s2);
        WriteReg = we;
        DstReg   = dst;
        DstData  = data;
        SrcReg1  = s1;
        SrcReg2  = s2;
    endtask

    // Advance one rising edge, commit the pending write to the model, and
    // leave the bench 1 ns after the edge ready to drive the next cycle.
    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b0) clear_model();
        else if (WriteReg === 1'b1 && DstReg != 4'd0) ref_regs[DstReg] = DstData;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd9);
        clear_model();
        repeat (2) tick();
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (byp_a !== 16'h0000 || byp_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state actual=%h/%h required=0000/0000", byp_a, byp_b);
        end
        // Populate R5 and R9, then reset with no clock edge.
        tick();
        drive(1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd9);
        tick();
        drive(1'b1, 4'd9, 16'hBEEF, 4'd5, 4'd9);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd9);
        #1;
        n_checks++;
        if (nob_a !== 16'hBEEF || nob_b !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL reset_prefill actual=%h/%h required=beef/beef", nob_a, nob_b);
        end
        rst_n = 1'b0;
        clear_model();
        #1;
        n_checks++;
        if (byp_a !== 16'h0000 || byp_b !== 16'h0000 || nob_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset actual=%h/%h/%h required=0000", byp_a, byp_b, nob_a);
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (byp_a !== 16'h0000 || byp_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release actual=%h/%h required=0000/0000", byp_a, byp_b);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        drive(1'b1, 4'd3, 16'h1234, 4'd0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd4);
        #1;
        n_checks++;
        if (byp_a !== 16'h1234 || byp_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_rw actual=%h/%h required=1234/0000", byp_a, byp_b);
        end
        for (int a = 0; a < 16; a++) begin
            SrcReg1 = 4'(a);
            SrcReg2 = 4'(15 - a);
            #1;
            n_checks++;
            if (byp_a !== ((a == 3) ? 16'h1234 : 16'h0000) ||
                nob_b !== ((a == 12) ? 16'h1234 : 16'h0000)) begin
                n_fail++;
                $display("FAIL basic_sweep addr=%0d actual=%h/%h", a, byp_a, nob_b);
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_r0();
        drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
        #1;
        n_checks++;
        if (byp_a !== 16'h0000 || byp_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL r0_bypass actual=%h/%h required=0000", byp_a, byp_b);
        end
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
        #1;
        n_checks++;
        if (byp_a !== 16'h0000 || nob_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL r0_store actual=%h/%h required=0000", byp_a, nob_a);
        end
        $display("test_r0 done");
    endtask

    task automatic test_bypass();
        drive(1'b1, 4'd7, 16'h00AA, 4'd0, 4'd0);
        tick();
        drive(1'b1, 4'd7, 16'h5555, 4'd7, 4'd7);
        #2;
        n_checks++;
        if (byp_a !== 16'h5555 || byp_b !== 16'h5555) begin
            n_fail++;
            $display("FAIL bypass_pre actual=%h/%h required=5555/5555", byp_a, byp_b);
        end
        n_checks++;
        if (nob_a !== 16'h00AA || nob_b !== 16'h00AA) begin
            n_fail++;
            $display("FAIL nobypass_pre actual=%h/%h required=00aa/00aa", nob_a, nob_b);
        end
        tick();
        drive(1'b0, 4'd7, 16'h0000, 4'd7, 4'd7);
        #1;
        n_checks++;
        if (byp_a !== 16'h5555 || byp_b !== 16'h5555 || nob_a !== 16'h5555 || nob_b !== 16'h5555) begin
            n_fail++;
            $display("FAIL bypass_post actual=%h/%h/%h/%h required=5555", byp_a, byp_b, nob_a, nob_b);
        end
        $display("test_bypass done");
    endtask

    task automatic test_gating();
        drive(1'b0, 4'd7, 16'hDEAD, 4'd7, 4'd3);
        #1;
        n_checks++;
        if (byp_a !== 16'h5555) begin
            n_fail++;
            $display("FAIL gating_pre actual=%h required=5555", byp_a);
        end
        tick();
        #1;
        n_checks++;
        if (byp_a !== 16'h5555 || nob_a !== 16'h5555 || byp_b !== 16'h1234) begin
            n_fail++;
            $display("FAIL gating_post actual=%h/%h/%h required=5555/5555/1234", byp_a, nob_a, byp_b);
        end
        $display("test_gating done");
    endtask

    task automatic test_reset_write();
        rst_n = 1'b0;
        clear_model();
        drive(1'b1, 4'd2, 16'hCAFE, 4'd2, 4'd7);
        tick();
        rst_n = 1'b1;
        WriteReg = 1'b0;
        #1;
        n_checks++;
        if (byp_a !== 16'h0000 || nob_a !== 16'h0000 || byp_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_write actual=%h/%h/%h required=0000", byp_a, nob_a, byp_b);
        end
        WriteReg = 1'b1;
        tick();
        WriteReg = 1'b0;
        #1;
        n_checks++;
        if (nob_a !== 16'hCAFE || byp_a !== 16'hCAFE) begin
            n_fail++;
            $display("FAIL write_after_reset actual=%h/%h required=cafe", nob_a, byp_a);
        end
        $display("test_reset_write done");
    endtask

    task automatic test_x_enable();
        // Known contents everywhere, then an unknown enable aimed at R6.
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 4'(i), 16'(16'h1000 + i), 4'd0, 4'd0);
            tick();
        end
        drive(1'bx, 4'd6, 16'hF00D, 4'd0, 4'd0);
        tick();
        ref_regs[6] = 16'hxxxx;
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
        for (int a = 1; a < 16; a++) begin
            if (a == 6) continue;
            SrcReg1 = 4'(a);
            #1;
            n_checks++;
            if (nob_a !== 16'(16'h1000 + a)) begin
                n_fail++;
                $display("FAIL x_enable addr=%0d actual=%h required=%h", a, nob_a, 16'(16'h1000 + a));
            end
        end
        // Restore R6 to a known value for the random phase.
        drive(1'b1, 4'd6, 16'h1006, 4'd0, 4'd0);
        tick();
        $display("test_x_enable done");
    endtask

    task automatic test_random();
        logic [15:0] e1a, e1b, e0a, e0b;
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) SrcReg2 = DstReg;
            #2;
            e1a = expect_read(SrcReg1, 1'b1);
            e1b = expect_read(SrcReg2, 1'b1);
            e0a = expect_read(SrcReg1, 1'b0);
            e0b = expect_read(SrcReg2, 1'b0);
            n_checks++;
            if (byp_a !== e1a || byp_b !== e1b) begin
                n_fail++;
                $display("FAIL random_bypass n=%0d we=%b dst=%0d s1=%0d s2=%0d actual=%h/%h required=%h/%h",
                         n, WriteReg, DstReg, SrcReg1, SrcReg2, byp_a, byp_b, e1a, e1b);
            end
            n_checks++;
            if (nob_a !== e0a || nob_b !== e0b) begin
                n_fail++;
                $display("FAIL random_stored n=%0d we=%b dst=%0d s1=%0d s2=%0d actual=%h/%h required=%h/%h",
                         n, WriteReg, DstReg, SrcReg1, SrcReg2, nob_a, nob_b, e0a, e0b);
            end
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
        clear_model();
        #1;
        test_reset();
        test_basic();
        test_r0();
        test_bypass();
        test_gating();
        test_reset_write();
        test_x_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 16-entry x 16-bit register file for the WISC datapath, in the decode stage.
- Directly consumes the one-hot write wordline from the 4-to-16 write decoder (WriteDecoder_4_16).
- Provides two combinational read ports and one clocked write port.
- Write-to-read bypass lets an instruction in decode see a value being written back in the same cycle.
- R0 is hardwired to zero.

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- ADDR_W, 4, register address width.
- NUM_REGS, 16, number of entries; must equal 2**ADDR_W.
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return the stored value only.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- SrcReg1  in  4  read port 1 address.
- SrcReg2  in  4  read port 2 address.
- DstReg  in  4  write address; drives the internal write decoder.
- WriteReg  in  1  write enable.
- DstData  in  16  write data.
- SrcData1  out  16  read port 1 data.
- SrcData2  out  16  read port 2 data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - rst_n low immediately clears all 16 entries to 16'h0000, without waiting for a clock edge.
  - SrcData1/SrcData2 therefore read 16'h0000 while in reset.
  - Release is synchronous to clk; the first write is accepted on the first rising edge with rst_n high.
- Write:
  - The internal decoder produces Wordline[15:0] = WriteReg ? (16'h0001 << DstReg) : 16'h0000.
  - On a rising clk, every entry i with Wordline[i]=1 and i!=0 loads DstData.
  - All other entries hold.
  - Write latency is 1 cycle: the value is stored at that edge.
- R0: entry 0 never stores. A write to DstReg=0 is silently dropped, and reads of address 0 always return 16'h0000, including through the bypass path.
- Read:
  - Purely combinational from the address to SrcDataN; no read latency.
  - Both ports are independent and may address the same register.
- Bypass (BYPASS_EN=1):
  - When WriteReg=1, DstReg!=0 and SrcRegN==DstReg, SrcDataN = DstData in the same cycle, before the edge.
  - The path is combinational. DstData must settle within the cycle, and the output must not depend on the previous stored value.
  - Forwarding applies to both ports simultaneously if both match.
  - WriteReg=0 disables forwarding regardless of address match.
- BYPASS_EN=0: a read in the write cycle returns the old value; the new value is visible from the cycle after the edge.
- Reset mid-write: if rst_n asserts in the same cycle as a write, reset wins and the entry is 16'h0000 after reset.
- Unknown inputs: an X on WriteReg must not corrupt any register other than the addressed one.
- No other state, counters or handshakes exist. The register file is always ready, and hazard stalling is the responsibility of the pipeline control.

Decomposition:
- Shared package (wisc_pkg): DATA_W=16, ADDR_W=4, NUM_REGS=16, ZERO_REG=4'd0, and a reg_addr_t/reg_data_t typedef pair shared with decode and writeback.
- Sub-module: instantiate the existing WriteDecoder_4_16 for wordline generation. The storage array, R0 mask and bypass mux stay in the top module; no extra sub-module is needed.

Test Plan:
- Async reset: write 16'hBEEF to R5 and R9, then drop rst_n mid-cycle with no clk edge -> SrcData1(R5) and SrcData2(R9) read 16'h0000 immediately, and stay 0 after release with no writes.
- Basic write/read: WriteReg=1, DstReg=3, DstData=16'h1234 at an edge; then WriteReg=0, SrcReg1=3, SrcReg2=4 -> SrcData1=16'h1234, SrcData2=16'h0000; all other entries unchanged (sweep all 16 addresses).
- R0 protection: WriteReg=1, DstReg=0, DstData=16'hFFFF, SrcReg1=0 in the same cycle and the next -> SrcData1=16'h0000 both cycles (no bypass, no store).
- Bypass both ports: R7 holds 16'h00AA; WriteReg=1, DstReg=7, DstData=16'h5555, SrcReg1=SrcReg2=7 -> both outputs 16'h5555 before the edge and after it. With BYPASS_EN=0 -> 16'h00AA before the edge, 16'h5555 after it.
- Write-enable gating: WriteReg=0, DstReg=7, DstData=16'hDEAD, SrcReg1=7 -> SrcData1 keeps the old value; a later read of R7 is unchanged.
- Reset during write: rst_n low while WriteReg=1, DstReg=2, DstData=16'hCAFE across an edge -> R2=16'h0000 after reset release; the next edge with rst_n high writes 16'hCAFE correctly.
